// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator on the processor data bus: one read then one write
// per word, with a per-phase DataDone timeout and an external Abort.
module bus_dma_master #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] SrcAddr,
  input  logic [15:0] DstAddr,
  input  logic [15:0] Count,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] Remaining,
  output logic        ReadData,
  output logic        WriteData,
  output logic [15:0] DataAddr,
  output logic [15:0] BusWrData,
  input  logic [15:0] BusRdData,
  input  logic        DataDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [15:0]   src_ptr_q, src_ptr_d;
  logic [15:0]   dst_ptr_q, dst_ptr_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          error_q, error_d;
  logic [TW-1:0] timer_q, timer_d;

  logic in_phase;
  logic phase_fail;

  assign in_phase = (state_q == S_READ) || (state_q == S_WRITE);
  // A completing phase always wins over Abort/timeout so its effects are kept.
  assign phase_fail = !DataDone && (Abort || (timer_q == TIMER_LAST));

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    error_d     = error_q;
    timer_d     = timer_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (Start) begin
          error_d = 1'b0;
          if (Count != '0) begin
            src_ptr_d   = SrcAddr;
            dst_ptr_d   = DstAddr;
            remaining_d = Count;
            state_d     = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_READ: begin
        if (DataDone) begin
          data_d  = BusRdData;
          timer_d = '0;
          if (Abort) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else if (phase_fail) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WRITE: begin
        if (DataDone) begin
          src_ptr_d   = src_ptr_q + 16'd1;
          dst_ptr_d   = dst_ptr_q + 16'd1;
          remaining_d = remaining_q - 16'd1;
          timer_d     = '0;
          if (Abort) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (remaining_q == 16'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else if (phase_fail) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
      timer_q     <= timer_d;
    end
  end

  // Bus-facing outputs decode registered state only.
  assign Busy      = in_phase;
  assign Done      = (state_q == S_DONE);
  assign Error     = error_q;
  assign Remaining = remaining_q;
  assign ReadData  = (state_q == S_READ);
  assign WriteData = (state_q == S_WRITE);
  assign BusWrData = data_q;

  always_comb begin
    DataAddr = '0;
    if (state_q == S_READ) begin
      DataAddr = src_ptr_q;
    end else if (state_q == S_WRITE) begin
      DataAddr = dst_ptr_q;
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: memory bus model with configurable wait states,
// sequential-copy reference model, directed corner cases and random copies.
module tb_bus_dma_master;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] SrcAddr = '0;
  logic [15:0] DstAddr = '0;
  logic [15:0] Count = '0;
  logic        Abort = 1'b0;
  logic        Busy, Done, Error, ReadData, WriteData;
  logic [15:0] Remaining, DataAddr, BusWrData;
  logic [15:0] BusRdData = '0;
  logic        DataDone = 1'b0;

  bus_dma_master #(.TIMEOUT(64), .TW(7)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Count(Count), .Abort(Abort), .Busy(Busy),
    .Done(Done), .Error(Error), .Remaining(Remaining), .ReadData(ReadData),
    .WriteData(WriteData), .DataAddr(DataAddr), .BusWrData(BusWrData),
    .BusRdData(BusRdData), .DataDone(DataDone)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus model ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] model_mem [0:65535];
  int rd_lat = 0, wr_lat = 0;
  bit rd_hang = 0, rand_lat = 0;
  int ph_cnt = 0, cur_lat = 0;
  logic [15:0] rd_log[$], wa_log[$], wd_log[$];
  logic [15:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int overlap = 0, done_cnt = 0, strobe_cyc = 0, busy_err = 0;

  always @(negedge Clock) begin
    if (!(ReadData || WriteData)) begin
      DataDone = 1'b0;
      ph_cnt = 0;
    end else begin
      if (DataDone) ph_cnt = 0;
      if (ph_cnt == 0)
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : (ReadData ? rd_lat : wr_lat);
      DataDone = (ReadData && rd_hang) ? 1'b0 : (ph_cnt >= cur_lat);
      BusRdData = mem[DataAddr];
      ph_cnt++;
    end
  end

  always @(posedge Clock) begin
    if (DataDone && ReadData) rd_log.push_back(DataAddr);
    if (DataDone && WriteData) begin
      mem[DataAddr] <= BusWrData;
      wa_log.push_back(DataAddr);
      wd_log.push_back(BusWrData);
    end
  end

  always @(negedge Clock) begin
    if (ReadData && WriteData) overlap++;
    if (Done) done_cnt++;
    if (ReadData || WriteData) strobe_cyc++;
    if (Busy !== (ReadData || WriteData)) busy_err++;
  end

  // ---------------- reference model ----------------
  task automatic run_model(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    logic [15:0] ra, wa;
    model_mem = mem;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < int'(c); i++) begin
      ra = s + 16'(i);
      wa = d + 16'(i);
      exp_rd.push_back(ra);
      exp_wa.push_back(wa);
      exp_wd.push_back(model_mem[ra]);
      model_mem[wa] = model_mem[ra];
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    overlap = 0; done_cnt = 0; strobe_cyc = 0; busy_err = 0;
  endtask

  task automatic start_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
    @(negedge Clock);
    SrcAddr = s; DstAddr = d; Count = c; Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  // Counts clock edges after the Start edge until Done is seen.
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (Done !== 1'b1 && cyc < max) begin
      @(posedge Clock);
      #1;
      cyc++;
    end
    if (Done !== 1'b1) check_eq("done_wait_expired", 0, 1);
  endtask

  task automatic compare_logs();
    check_eq("rd_count", rd_log.size(), exp_rd.size());
    check_eq("wr_count", wa_log.size(), exp_wa.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check_eq($sformatf("rd_addr[%0d]", i), rd_log[i], exp_rd[i]);
    for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++) begin
      check_eq($sformatf("wr_addr[%0d]", i), wa_log[i], exp_wa[i]);
      check_eq($sformatf("wr_data[%0d]", i), wd_log[i], exp_wd[i]);
    end
  endtask

  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c,
                         output int cyc);
    run_model(s, d, c);
    clear_logs();
    start_xfer(s, d, c);
    check_eq("busy_after_start", Busy, 1);
    check_eq("error_cleared", Error, 0);
    check_eq("remaining_loaded", Remaining, c);
    wait_done(20 * int'(c) + 20, cyc);
    check_eq("error_final", Error, 0);
    check_eq("remaining_final", Remaining, 0);
    check_eq("busy_in_done", Busy, 0);
    @(posedge Clock);
    #1;
    check_eq("done_one_cycle", Done, 0);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("strobe_overlap", overlap, 0);
    check_eq("busy_vs_strobes", busy_err, 0);
    compare_logs();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [15:0] s, d, c, exp_word;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge Clock);
    #1;
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_error", Error, 0);
    check_eq("rst_rd", ReadData, 0);
    check_eq("rst_wr", WriteData, 0);
    check_eq("rst_addr", DataAddr, 0);
    check_eq("rst_wdata", BusWrData, 0);
    check_eq("rst_remaining", Remaining, 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Three-word copy, reads wait 2 cycles, writes complete at once.
    mem[16'h0010] = 16'hA1A1; mem[16'h0011] = 16'hB2B2; mem[16'h0012] = 16'hC3C3;
    rd_lat = 2; wr_lat = 0;
    do_copy(16'h0010, 16'h0100, 16'd3, cyc);
    check_eq("mem_0100", mem[16'h0100], 16'hA1A1);
    check_eq("mem_0101", mem[16'h0101], 16'hB2B2);
    check_eq("mem_0102", mem[16'h0102], 16'hC3C3);

    // Zero-wait bus: two edges per word between Start edge and Done.
    rd_lat = 0; wr_lat = 0;
    do_copy(16'h0300, 16'h0400, 16'd3, cyc);
    check_eq("zero_wait_latency", cyc, 6);

    // Address wrap at 0xFFFF.
    do_copy(16'hFFFF, 16'h1FFF, 16'd2, cyc);

    // Read never completes: timeout after 64 strobe cycles.
    rd_hang = 1;
    clear_logs();
    start_xfer(16'h0040, 16'h0080, 16'd5);
    wait_done(200, cyc);
    check_eq("to_latency", cyc, 64);
    check_eq("to_error", Error, 1);
    check_eq("to_remaining", Remaining, 5);
    check_eq("to_rd_dropped", ReadData, 0);
    @(posedge Clock);
    #1;
    check_eq("to_strobe_cycles", strobe_cyc, 64);
    check_eq("to_done_pulses", done_cnt, 1);
    check_eq("to_no_writes", wa_log.size(), 0);
    rd_hang = 0;

    // Count=0 also clears the sticky error, with no bus traffic.
    clear_logs();
    start_xfer(16'h0001, 16'h0002, 16'd0);
    wait_done(5, cyc);
    check_eq("c0_latency", cyc, 0);
    check_eq("c0_error", Error, 0);
    repeat (3) @(posedge Clock);
    #1;
    check_eq("c0_no_strobes", strobe_cyc, 0);
    check_eq("c0_done_pulses", done_cnt, 1);

    // Abort coinciding with the first write completion.
    rd_lat = 1; wr_lat = 1;
    exp_word = mem[16'h0200];
    clear_logs();
    start_xfer(16'h0200, 16'h0300, 16'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      #1;
      if (WriteData && DataDone) break;
    end
    Abort = 1'b1;
    @(posedge Clock);
    #1 Abort = 1'b0;
    wait_done(5, cyc);
    check_eq("ab_done_now", cyc, 0);
    check_eq("ab_remaining", Remaining, 3);
    check_eq("ab_error", Error, 1);
    repeat (10) @(posedge Clock);
    #1;
    check_eq("ab_writes", wa_log.size(), 1);
    check_eq("ab_reads", rd_log.size(), 1);
    if (wa_log.size() > 0) begin
      check_eq("ab_wr_addr", wa_log[0], 16'h0300);
      check_eq("ab_wr_data", wd_log[0], exp_word);
    end
    check_eq("ab_done_pulses", done_cnt, 1);

    // Asynchronous reset in the middle of a write phase.
    rd_lat = 3; wr_lat = 3;
    clear_logs();
    start_xfer(16'h0500, 16'h0600, 16'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      #1;
      if (WriteData) break;
    end
    Reset = 1'b1;
    #1;
    check_eq("rs_wr_low", WriteData, 0);
    check_eq("rs_rd_low", ReadData, 0);
    check_eq("rs_busy", Busy, 0);
    check_eq("rs_remaining", Remaining, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check_eq("rs_no_done", done_cnt, 0);
    do_copy(16'h0700, 16'h0800, 16'd2, cyc);

    // Random copies with random wait states (overlapping ranges allowed).
    rand_lat = 1;
    for (int n = 0; n < 10; n++) begin
      s = 16'($urandom);
      d = (n % 3 == 0) ? s + 16'($urandom_range(1, 3)) : 16'($urandom);
      c = 16'($urandom_range(1, 6));
      do_copy(s, d, c, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
